// File: rtl/vram_arbiter.sv
// Arbitrates the single-port VRAM between the CPU and GPU with request/acknowledge handshakes,
// round-robin tie breaking and a GPU exclusive lock that is forcibly broken if the CPU starves.
module vram_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 16,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CPU_REQ,
    input  logic              CPU_WRITE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic              CPU_ACK,
    output logic              CPU_RVALID,
    output logic [DATA_W-1:0] CPU_RDATA,
    input  logic              GPU_REQ,
    input  logic              GPU_WRITE,
    input  logic [ADDR_W-1:0] GPU_ADDR,
    input  logic [DATA_W-1:0] GPU_WDATA,
    output logic              GPU_ACK,
    output logic              GPU_RVALID,
    output logic [DATA_W-1:0] GPU_RDATA,
    input  logic              GPU_LOCK,
    output logic              GPU_OWNS,
    output logic              LOCK_BROKEN,
    output logic              VRAM_ENABLE,
    output logic              VRAM_WRITE,
    output logic [ADDR_W-1:0] VRAM_ADDR,
    output logic [DATA_W-1:0] VRAM_DATA_W,
    input  logic [DATA_W-1:0] VRAM_DATA_R
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_BREAK = CNT_W'(LOCK_TIMEOUT - 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        SHARED,
        LOCKED,
        BROKEN
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lastGpu_q, lastGpu_d;
    logic             lockBroken_q, lockBroken_d;
    logic             gpuOwns_q;
    logic             rdCpu_q, rdGpu_q;
    logic             cpuGrant, gpuGrant;

    // Grants are suppressed while RESET is high so every output drops immediately.
    always_comb begin
        cpuGrant = 1'b0;
        gpuGrant = 1'b0;
        if (!RESET) begin
            case (state_q)
                SHARED: begin
                    cpuGrant = CPU_REQ && (!GPU_REQ || lastGpu_q);
                    gpuGrant = GPU_REQ && !cpuGrant;
                end
                LOCKED:  gpuGrant = GPU_REQ;
                BROKEN:  cpuGrant = CPU_REQ;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lastGpu_d    = lastGpu_q;
        lockBroken_d = lockBroken_q;
        if (cpuGrant) begin
            lastGpu_d = 1'b0;
        end else if (gpuGrant) begin
            lastGpu_d = 1'b1;
        end
        case (state_q)
            SHARED: begin
                cnt_d = '0;
                if (GPU_LOCK) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (!GPU_LOCK) begin
                    state_d = SHARED;
                    cnt_d   = '0;
                end else if (CPU_REQ) begin
                    // Counter reaching LOCK_TIMEOUT-1 at this edge means the CPU has waited long enough.
                    if (cnt_q >= CNT_BREAK) begin
                        state_d      = BROKEN;
                        lockBroken_d = 1'b1;
                    end
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            BROKEN: begin
                cnt_d     = '0;
                lastGpu_d = 1'b0;
                state_d   = GPU_LOCK ? LOCKED : SHARED;
            end
            default: begin
                state_d = SHARED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= SHARED;
            cnt_q        <= '0;
            lastGpu_q    <= 1'b1;
            lockBroken_q <= 1'b0;
            gpuOwns_q    <= 1'b0;
            rdCpu_q      <= 1'b0;
            rdGpu_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lastGpu_q    <= lastGpu_d;
            lockBroken_q <= lockBroken_d;
            gpuOwns_q    <= (state_d == LOCKED);
            rdCpu_q      <= cpuGrant && !CPU_WRITE;
            rdGpu_q      <= gpuGrant && !GPU_WRITE;
        end
    end

    always_comb begin
        VRAM_ENABLE = 1'b0;
        VRAM_WRITE  = 1'b0;
        VRAM_ADDR   = '0;
        VRAM_DATA_W = '0;
        if (cpuGrant) begin
            VRAM_ENABLE = 1'b1;
            VRAM_WRITE  = CPU_WRITE;
            VRAM_ADDR   = CPU_ADDR;
            VRAM_DATA_W = CPU_WRITE ? CPU_WDATA : '0;
        end else if (gpuGrant) begin
            VRAM_ENABLE = 1'b1;
            VRAM_WRITE  = GPU_WRITE;
            VRAM_ADDR   = GPU_ADDR;
            VRAM_DATA_W = GPU_WRITE ? GPU_WDATA : '0;
        end
    end

    assign CPU_ACK     = cpuGrant;
    assign GPU_ACK     = gpuGrant;
    assign CPU_RVALID  = rdCpu_q;
    assign GPU_RVALID  = rdGpu_q;
    assign CPU_RDATA   = rdCpu_q ? VRAM_DATA_R : '0;
    assign GPU_RDATA   = rdGpu_q ? VRAM_DATA_R : '0;
    assign GPU_OWNS    = gpuOwns_q;
    assign LOCK_BROKEN = lockBroken_q;

endmodule
